seq_add_ctrl: RTL and testbench
===============================

SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 100: operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK_W, default 25: bits added per cycle; WIDTH % CHUNK_W == 0 is mandatory, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-007 SHALL have port a, input, WIDTH bits: operand A.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: carry-in.
REQ-010 SHALL have port flush, input, 1 bit: synchronous abort to IDLE.
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-013 SHALL have port sum, output, WIDTH bits: a+b+cin modulo 2^WIDTH.
REQ-014 SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-015 SHALL have port busy, output, 1 bit: high in RUN.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; NUM_CHUNKS = WIDTH/CHUNK_W (default 4).
REQ-017 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE; busy=1 only in RUN.
REQ-018 On an IDLE edge with in_valid&&in_ready, SHALL register a, b, cin, clear the chunk index to 0, and go to RUN.
REQ-019 In RUN, each edge SHALL add chunk k of the registered operands plus the registered carry, write sum chunk k, register the chunk carry, and increment k.
REQ-020 On the edge processing chunk NUM_CHUNKS-1, SHALL register cout and go to DONE; out_valid rises NUM_CHUNKS edges after the accepting edge (4 by default).
REQ-021 In DONE, sum and cout SHALL hold stable until out_valid&&out_ready, then go to IDLE; minimum issue interval is NUM_CHUNKS+2 cycles.
REQ-022 Operand inputs SHALL be ignored outside the accepting edge; changes during RUN SHALL not affect the result.
REQ-023 flush=1 SHALL force IDLE on the next edge from any state, discarding work; sum/cout keep their last values; flush has priority over acceptance and completion on the same edge.
REQ-024 The carry SHALL ripple across chunk boundaries exactly; the result SHALL be bit-identical to a WIDTH-bit full add.

Reset
REQ-025 While rst_n=0: state=IDLE, chunk index=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
REQ-026 Reset asserted mid-RUN or in DONE SHALL drop the transaction; no result is produced after deassertion.

Configuration
REQ-027 With SEQ_ADD_OVF_EN defined, SHALL add output ovf (1 bit), registered with cout, equal to two's-complement signed overflow of a+b+cin (carry into MSB XOR carry out), reset 0, held in DONE.
REQ-028 Without SEQ_ADD_OVF_EN, port ovf and its logic SHALL be absent.

Structure
REQ-029 SHALL place the FSM state enum type and a NUM_CHUNKS helper function in package seq_add_pkg.
REQ-030 SHALL instantiate one combinational sub-module add_chunk (CHUNK_W-bit a, b, cin -> sum, cout, built as full-adder cells) for all chunks.

Verification
REQ-031 SHALL cover a=all ones, b=0, cin=1 -> sum=0, cout=1, out_valid exactly 4 cycles after the handshake.
REQ-032 SHALL cover a=0x1FFFFFF (2^25-1), b=1, cin=0 -> sum=0x2000000, cout=0, proving the carry crosses the chunk 0/1 boundary.
REQ-033 SHALL cover out_ready held low 10 cycles in DONE -> sum/cout stable, in_ready=0, then IDLE one edge after out_ready=1.
REQ-034 SHALL cover rst_n pulsed low in RUN (k=2) -> all outputs 0, in_ready=1; no out_valid follows.
REQ-035 SHALL cover flush in RUN concurrent with in_valid -> IDLE next edge with no acceptance; the next transaction a=5, b=7 -> sum=12.
REQ-036 SHALL cover, with SEQ_ADD_OVF_EN, a=0x7F..F (signed max), b=1 -> ovf=1, cout=0; a=b=all ones -> ovf=0, cout=1.

Source files
------------

// File: rtl/seq_add_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// Holds the FSM state encoding and chunk-count arithmetic.
package seq_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int num_chunks(input int width, input int chunk_w);
        return width / chunk_w;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_add_ctrl_add_chunk.sv
// Combinational W-bit ripple adder slice built from full-adder cells.
// One instance is time-shared across every chunk of the operands.
module add_chunk #(
    parameter int W = 25
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/seq_add_ctrl.sv
// Multi-cycle WIDTH-bit adder: one CHUNK_W slice per clock, valid/ready on both sides.
// Define SEQ_ADD_OVF_EN to add the registered signed-overflow output ovf.
module seq_add_ctrl
    import seq_add_pkg::*;
#(
    parameter int WIDTH   = 100,
    parameter int CHUNK_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NC = num_chunks(WIDTH, CHUNK_W);
    localparam int KW = idx_width(NC);

    if ((CHUNK_W <= 0) || (WIDTH % CHUNK_W != 0)) begin : g_bad_cfg
        $error("seq_add_ctrl: WIDTH must be a multiple of CHUNK_W");
    end

    state_e           state;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;

    logic [CHUNK_W-1:0] a_c;
    logic [CHUNK_W-1:0] b_c;
    logic [CHUNK_W-1:0] s_c;
    logic               co_c;

    assign a_c = a_q[int'(k_q)*CHUNK_W +: CHUNK_W];
    assign b_c = b_q[int'(k_q)*CHUNK_W +: CHUNK_W];

    add_chunk #(
        .W(CHUNK_W)
    ) u_add (
        .a   (a_c),
        .b   (b_c),
        .cin (carry_q),
        .sum (s_c),
        .cout(co_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (flush) begin
            // Abort wins over accept/complete; result regs keep old contents.
            state     <= S_IDLE;
            k_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        k_q      <= '0;
                        state    <= S_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    sum[int'(k_q)*CHUNK_W +: CHUNK_W] <= s_c;
                    carry_q <= co_c;
                    if (k_q == KW'(NC - 1)) begin
                        cout      <= co_c;
`ifdef SEQ_ADD_OVF_EN
                        // Carry into the MSB is recovered from the MSB sum bit.
                        ovf <= co_c ^ (a_c[CHUNK_W-1] ^ b_c[CHUNK_W-1]
                                       ^ s_c[CHUNK_W-1]);
`endif
                        k_q       <= '0;
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    k_q       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Self-checking bench for seq_add_ctrl: vector table, corner sequences, random model.
// Build with SEQ_ADD_OVF_EN defined to also check the ovf output.
module tb_seq_add_ctrl;

    localparam int W = 100;
    localparam int LAT = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SEQ_ADD_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad = 0;

    seq_add_ctrl #(
        .WIDTH  (W),
        .CHUNK_W(25)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
`ifdef SEQ_ADD_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Reference: plain wide arithmetic plus the sign rule for overflow.
    function automatic logic [W:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic c);
        logic [W:0] r;
        r = model(x, y, c);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input int hold,
                           output logic [W-1:0] rs, output logic rc,
                           output logic ro, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        a = ta;
        b = tb;
        cin = tc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = rnd();
        b = rnd();
        cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        repeat (hold) tick();
        rs = sum;
        rc = cout;
`ifdef SEQ_ADD_OVF_EN
        ro = ovf;
`else
        ro = 1'b0;
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] maxp;
        logic [W-1:0] minn;
        logic [W-1:0] rs;
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        logic [W:0]   ref_r;
        logic         rc;
        logic         ro;
        logic         tc;
        logic         seen;
        int           lat;

        ones = '1;
        maxp = {1'b0, {(W-1){1'b1}}};
        minn = {1'b1, {(W-1){1'b0}}};

        tbl[0] = '{ones, '0, 1'b1, '0, 1'b1, 1'b0};
        tbl[1] = '{W'(100'h1FFFFFF), W'(100'h1), 1'b0,
                   W'(100'h2000000), 1'b0, 1'b0};
        tbl[2] = '{W'(100'd5), W'(100'd7), 1'b0, W'(100'd12), 1'b0, 1'b0};
        tbl[3] = '{W'((100'h1 << 75) - 1), W'(100'h1), 1'b0,
                   W'(100'h1 << 75), 1'b0, 1'b0};
        tbl[4] = '{ones, ones, 1'b1, ones, 1'b1, 1'b0};
        tbl[5] = '{maxp, W'(100'h1), 1'b0, minn, 1'b0, 1'b1};
        tbl[6] = '{ones, ones, 1'b0, {ones[W-1:1], 1'b0}, 1'b1, 1'b0};
        tbl[7] = '{minn, minn, 1'b0, '0, 1'b1, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef SEQ_ADD_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].a, tbl[i].b, tbl[i].cin, 0, rs, rc, ro, lat);
            chk($sformatf("tbl%0d_sum", i), rs, tbl[i].s);
            chk($sformatf("tbl%0d_cout", i), rc, tbl[i].co);
            chk($sformatf("tbl%0d_lat", i), lat, LAT);
`ifdef SEQ_ADD_OVF_EN
            chk($sformatf("tbl%0d_ovf", i), ro, tbl[i].ov);
`endif
            chk($sformatf("tbl%0d_idle", i), in_ready, 1);
        end

        // Consumer stall in DONE.
        ta = rnd();
        tb = rnd();
        ref_r = model(ta, tb, 1'b1);
        a = ta;
        b = tb;
        cin = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("run_busy", busy, 1);
            tick();
            lat++;
        end
        chk("stall_lat", lat, LAT);
        for (int i = 0; i < 10; i++) begin
            chk("stall_sum", sum, ref_r[W-1:0]);
            chk("stall_cout", cout, ref_r[W]);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_release_idle", in_ready, 1);
        chk("stall_release_ov", out_valid, 0);

        // Reset pulse while chunk index is 2.
        a = rnd();
        b = rnd();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_rst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid | busy;
        end
        chk("mid_rst_no_result", seen, 0);

        // Flush in IDLE beats a concurrent acceptance.
        a = rnd();
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_busy", busy, 0);
        chk("flush_idle_ready", in_ready, 1);

        // Flush during RUN with a new offer on the same edge.
        a = rnd();
        b = rnd();
        in_valid = 1'b1;
        tick();
        tick();
        a = rnd();
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_run_ready", in_ready, 1);
        chk("flush_run_busy", busy, 0);
        tick();
        chk("flush_run_no_accept", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | out_valid;
        end
        chk("flush_run_no_result", seen, 0);
        run_txn(W'(100'd5), W'(100'd7), 1'b0, 0, rs, rc, ro, lat);
        chk("after_flush_sum", rs, 12);
        chk("after_flush_cout", rc, 0);

        // Randomized traffic against the wide-arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ta = rnd();
            tb = rnd();
            tc = 1'($urandom);
            if (i % 8 == 3) ta = ones ^ tb;
            ref_r = model(ta, tb, tc);
            run_txn(ta, tb, tc, int'($urandom_range(0, 3)), rs, rc, ro, lat);
            chk("rand_sum", rs, ref_r[W-1:0]);
            chk("rand_cout", rc, ref_r[W]);
            chk("rand_lat", lat, LAT);
`ifdef SEQ_ADD_OVF_EN
            chk("rand_ovf", ro, model_ovf(ta, tb, tc));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
